// File: rtl/rect_fill_engine.sv
// rtl/rect_fill_engine.sv - Queued rectangle fill/outline rasteriser driving a frame-buffer write port

module rect_fill_engine #(
    parameter int SCR_W     = 160,
    parameter int SCR_H     = 120,
    parameter int XW        = 8,
    parameter int YW        = 7,
    parameter int ADDR_W    = 15,
    parameter int COLOR_W   = 3,
    parameter int DEPTH     = 4,
    parameter int WE_CYCLES = 2
) (
    input  logic               Clck,
    input  logic               Reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [XW-1:0]      cmd_x0,
    input  logic [YW-1:0]      cmd_y0,
    input  logic [XW-1:0]      cmd_x1,
    input  logic [YW-1:0]      cmd_y1,
    input  logic [COLOR_W-1:0] cmd_color,
    input  logic               cmd_outline,
    output logic [ADDR_W-1:0]  address,
    output logic [COLOR_W-1:0] color,
    output logic               wr_en,
    output logic               cmd_done,
    output logic               busy
);

    localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW  = PW + 1;
    localparam int WCW = $clog2(WE_CYCLES + 1);
    localparam logic [ADDR_W-1:0] SCR_W_A = ADDR_W'(SCR_W);

    typedef enum logic [2:0] {IDLE, LOAD, WRITE, STEP, DONE} state_t;

    typedef struct packed {
        logic [XW-1:0]      x0;
        logic [YW-1:0]      y0;
        logic [XW-1:0]      x1;
        logic [YW-1:0]      y1;
        logic [COLOR_W-1:0] color;
        logic               outline;
    } cmd_t;

    cmd_t             mem [DEPTH];
    cmd_t             cmd_in;
    cmd_t             head;
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    count;
    logic             push, pop;

    state_t           state, state_d;
    logic [XW-1:0]    x, x_d, x0_r, xe_r, xe_clip;
    logic [YW-1:0]    y, y_d, y0_r, ye_r, ye_clip;
    logic [COLOR_W-1:0] col_r;
    logic             outl_r;
    logic [WCW-1:0]   we_cnt, we_cnt_d;
    logic             wr_en_d, load, degenerate;
    logic             x_last, y_last, edge_row;

    assign cmd_in    = {cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_color, cmd_outline};
    assign head      = mem[rd_ptr];
    assign cmd_ready = (count != CW'(DEPTH));
    assign push      = cmd_valid && cmd_ready;
    assign busy      = (count != '0) || (state != IDLE);

    always_ff @(posedge Clck) begin
        if (push) begin
            mem[wr_ptr] <= cmd_in;
        end
    end

    always_ff @(posedge Clck) begin
        if (!Reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Clip the exclusive end corner to the screen before deciding whether anything is drawn
    assign xe_clip    = (head.x1 > XW'(SCR_W)) ? XW'(SCR_W) : head.x1;
    assign ye_clip    = (head.y1 > YW'(SCR_H)) ? YW'(SCR_H) : head.y1;
    assign degenerate = (head.x0 >= xe_clip) || (head.y0 >= ye_clip);

    assign x_last   = (x == xe_r - 1'b1);
    assign y_last   = (y == ye_r - 1'b1);
    assign edge_row = (y == y0_r) || y_last;

    always_ff @(posedge Clck) begin
        if (!Reset) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d  = state;
        x_d      = x;
        y_d      = y;
        wr_en_d  = wr_en;
        we_cnt_d = we_cnt;
        pop      = 1'b0;
        load     = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    pop     = 1'b1;
                    x_d     = head.x0;
                    y_d     = head.y0;
                    state_d = degenerate ? DONE : LOAD;
                end
            end
            LOAD: begin
                load     = 1'b1;
                wr_en_d  = 1'b1;
                we_cnt_d = WCW'(1);
                state_d  = WRITE;
            end
            WRITE: begin
                if (we_cnt == WCW'(WE_CYCLES)) begin
                    wr_en_d = 1'b0;
                    state_d = STEP;
                end else begin
                    we_cnt_d = we_cnt + 1'b1;
                end
            end
            STEP: begin
                if (x_last && y_last) begin
                    state_d = DONE;
                end else begin
                    state_d = LOAD;
                    if (x_last) begin
                        x_d = x0_r;
                        y_d = y + 1'b1;
                    end else if (outl_r && !edge_row) begin
                        // interior outline rows only touch the left and right columns
                        x_d = xe_r - 1'b1;
                    end else begin
                        x_d = x + 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clck) begin
        if (!Reset) begin
            x        <= '0;
            y        <= '0;
            x0_r     <= '0;
            y0_r     <= '0;
            xe_r     <= '0;
            ye_r     <= '0;
            col_r    <= '0;
            outl_r   <= 1'b0;
            we_cnt   <= '0;
            address  <= '0;
            color    <= '0;
            wr_en    <= 1'b0;
            cmd_done <= 1'b0;
        end else begin
            x        <= x_d;
            y        <= y_d;
            we_cnt   <= we_cnt_d;
            wr_en    <= wr_en_d;
            cmd_done <= (state == DONE);
            if (pop) begin
                x0_r   <= head.x0;
                y0_r   <= head.y0;
                xe_r   <= xe_clip;
                ye_r   <= ye_clip;
                col_r  <= head.color;
                outl_r <= head.outline;
            end
            if (load) begin
                address <= ADDR_W'(y) * SCR_W_A + ADDR_W'(x);
                color   <= col_r;
            end
        end
    end

endmodule
